branch_resolve_ctrl: RTL and testbench
======================================

// Module: branch_resolve_ctrl
// PURPOSE
//   Tracks each fetched instruction's branch prediction from IF through ID to EX.
//   In EX it compares the prediction with the resolved outcome.
//   On a mismatch it sequences recovery: a registered redirect to the correct path,
//   a flush of the wrong-path instructions, and the update strobe for the 2-bit predictor.
//   It also keeps branch and mispredict statistics.
//   It sits between the predictor/fetch stage and the EX-stage branch comparator.
// PARAMETERS
//   CNT_W  16  width of the saturating performance counters
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous reset, active high
//   stall        in   1      pipeline hold request from the hazard unit
//   if_valid     in   1      IF stage holds a real instruction
//   if_pc        in   32     PC of the IF instruction
//   if_is_branch in   1      IF instruction is a conditional branch (opcode[6:2]==5'b11000)
//   if_predict   in   1      predictor output for the IF instruction (1 = taken)
//   if_imm       in   32     sign-extended B-type offset of the IF instruction
//   ex_b_take    in   1      resolved outcome of the EX instruction (1 = taken)
//   ex_b_check   out  1      EX holds a branch being resolved; drives the predictor state update
//   redirect     out  1      PC mux must select redirect_pc this cycle
//   redirect_pc  out  32     correct-path PC
//   flush        out  1      squash the IF/ID contents and the instruction in IF this cycle
//   br_count     out  CNT_W  number of resolved branches
//   mis_count    out  CNT_W  number of mispredicted branches
// BEHAVIOUR
//   Stage slots: ID and EX each hold {valid, is_br, pred, alt_pc}.
//   - alt_pc is the not-predicted path: pred ? pc+4 : pc+imm.
//   - 32-bit adds wrap modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
//   - alt_pc is computed when the IF inputs are captured into ID.
//   Slot advance in RUN with no mispredict:
//   - stall=0: ID <= IF inputs (valid = if_valid); EX <= ID.
//   - stall=1: ID holds; EX <= bubble (valid=0).
//   ex_b_check = EX.valid & EX.is_br & (state==RUN); combinational from registers.
//   mispredict = ex_b_check & (ex_b_take != EX.pred).
//   FSM states: RUN and REDIR.
//   - RUN, mispredict at the edge: state <= REDIR; redirect <= 1; flush <= 1;
//     redirect_pc <= EX.alt_pc; ID.valid <= 0; EX.valid <= 0.
//     flush/clear wins over stall.
//   - REDIR (exactly 1 cycle): redirect=1 and flush=1 are visible. The IF input is wrong-path and is ignored.
//     At the next edge: redirect <= 0; flush <= 0; ID/EX valid <= 0; state <= RUN.
//     This happens regardless of stall.
//   - ex_b_take is ignored in REDIR, since ex_b_check=0 there.
//   - Penalty: 3 wrong-path fetches are squashed. The first correct fetch is in IF on the cycle after REDIR.
//   Counters, evaluated at each edge in RUN:
//   - br_count++ when ex_b_check=1.
//   - mis_count++ when mispredict=1.
//   - Both saturate at all-ones and never wrap.
//   Reset (async, any cycle, including mid-REDIR):
//   - state = RUN; all slots invalid.
//   - redirect = 0, flush = 0, redirect_pc = 0, counters = 0.
//   - ex_b_check = 0 immediately.
//   Registered outputs: redirect, flush, redirect_pc, counters. No output depends combinationally on IF inputs.
// TESTING
//   1. Predict-taken branch at pc=0x100, imm=0x20, ex_b_take=1
//      -> no redirect/flush; ex_b_check=1 for 1 cycle; br_count=1, mis_count=0.
//   2. Same branch with ex_b_take=0
//      -> at the next edge redirect=1, flush=1, redirect_pc=0x104 for exactly 1 cycle;
//         mis_count=1; ID/EX valid=0.
//   3. Predict-not-taken branch at pc=0x200, imm=0xFFFFFFF0, ex_b_take=1
//      -> redirect_pc=0x1F0.
//   4. Branch reaches EX while stall=1 and is mispredicted
//      -> redirect/flush still assert on the next cycle; EX gets a bubble;
//         a branch held in ID is squashed, not evaluated.
//   5. Preload counters near saturation: 2^CNT_W-1 resolves of one type, then 2 more resolutions
//      -> br_count stays 0xFFFF (CNT_W=16).
//   6. Assert rst during the REDIR cycle
//      -> redirect, flush, ex_b_check drop to 0 immediately; counters=0; state RUN.
//   7. Wrap case: pc=0xFFFFFFFC, taken prediction wrong
//      -> redirect_pc=0x00000000.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - branch prediction tracking, EX-stage resolution and mispredict recovery
module branch_resolve_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic             if_is_branch,
    input  logic             if_predict,
    input  logic [31:0]      if_imm,
    input  logic             ex_b_take,
    output logic             ex_b_check,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mis_count
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_REDIR = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       state_q, state_d;
    logic             id_valid_q, id_valid_d;
    logic             id_is_br_q, id_is_br_d;
    logic             id_pred_q, id_pred_d;
    logic [31:0]      id_alt_pc_q, id_alt_pc_d;
    logic             ex_valid_q, ex_valid_d;
    logic             ex_is_br_q, ex_is_br_d;
    logic             ex_pred_q, ex_pred_d;
    logic [31:0]      ex_alt_pc_q, ex_alt_pc_d;
    logic             redirect_q, redirect_d;
    logic             flush_q, flush_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] mis_count_q, mis_count_d;
    logic             mispredict;
    logic [31:0]      if_alt_pc;

    // The slot remembers the path it did NOT take, so recovery needs no adder in EX.
    assign if_alt_pc = if_predict ? (if_pc + 32'd4) : (if_pc + if_imm);

    always_comb begin
        ex_b_check = ex_valid_q & ex_is_br_q & (state_q == ST_RUN);
        mispredict = ex_b_check & (ex_b_take != ex_pred_q);
    end

    always_comb begin
        state_d       = state_q;
        id_valid_d    = id_valid_q;
        id_is_br_d    = id_is_br_q;
        id_pred_d     = id_pred_q;
        id_alt_pc_d   = id_alt_pc_q;
        ex_valid_d    = ex_valid_q;
        ex_is_br_d    = ex_is_br_q;
        ex_pred_d     = ex_pred_q;
        ex_alt_pc_d   = ex_alt_pc_q;
        redirect_d    = redirect_q;
        flush_d       = flush_q;
        redirect_pc_d = redirect_pc_q;
        br_count_d    = br_count_q;
        mis_count_d   = mis_count_q;

        case (state_q)
            ST_RUN: begin
                if (mispredict) begin
                    // Recovery takes priority over a stall request.
                    state_d       = ST_REDIR;
                    redirect_d    = 1'b1;
                    flush_d       = 1'b1;
                    redirect_pc_d = ex_alt_pc_q;
                    id_valid_d    = 1'b0;
                    ex_valid_d    = 1'b0;
                end else if (stall) begin
                    ex_valid_d = 1'b0;
                end else begin
                    id_valid_d  = if_valid;
                    id_is_br_d  = if_is_branch;
                    id_pred_d   = if_predict;
                    id_alt_pc_d = if_alt_pc;
                    ex_valid_d  = id_valid_q;
                    ex_is_br_d  = id_is_br_q;
                    ex_pred_d   = id_pred_q;
                    ex_alt_pc_d = id_alt_pc_q;
                end
                if (ex_b_check && (br_count_q != CNT_MAX)) begin
                    br_count_d = br_count_q + 1'b1;
                end
                if (mispredict && (mis_count_q != CNT_MAX)) begin
                    mis_count_d = mis_count_q + 1'b1;
                end
            end
            ST_REDIR: begin
                state_d    = ST_RUN;
                redirect_d = 1'b0;
                flush_d    = 1'b0;
                id_valid_d = 1'b0;
                ex_valid_d = 1'b0;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            id_valid_q    <= 1'b0;
            id_is_br_q    <= 1'b0;
            id_pred_q     <= 1'b0;
            id_alt_pc_q   <= 32'd0;
            ex_valid_q    <= 1'b0;
            ex_is_br_q    <= 1'b0;
            ex_pred_q     <= 1'b0;
            ex_alt_pc_q   <= 32'd0;
            redirect_q    <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= 32'd0;
            br_count_q    <= '0;
            mis_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            id_valid_q    <= id_valid_d;
            id_is_br_q    <= id_is_br_d;
            id_pred_q     <= id_pred_d;
            id_alt_pc_q   <= id_alt_pc_d;
            ex_valid_q    <= ex_valid_d;
            ex_is_br_q    <= ex_is_br_d;
            ex_pred_q     <= ex_pred_d;
            ex_alt_pc_q   <= ex_alt_pc_d;
            redirect_q    <= redirect_d;
            flush_q       <= flush_d;
            redirect_pc_q <= redirect_pc_d;
            br_count_q    <= br_count_d;
            mis_count_q   <= mis_count_d;
        end
    end

    assign redirect    = redirect_q;
    assign flush       = flush_q;
    assign redirect_pc = redirect_pc_q;
    assign br_count    = br_count_q;
    assign mis_count   = mis_count_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - directed self-checking bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_is_branch;
    logic        if_predict;
    logic [31:0] if_imm;
    logic        ex_b_take;
    logic        ex_b_check;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [15:0] br_count;
    logic [15:0] mis_count;

    int checks;
    int errors;

    branch_resolve_ctrl #(.CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_is_branch (if_is_branch),
        .if_predict   (if_predict),
        .if_imm       (if_imm),
        .ex_b_take    (ex_b_take),
        .ex_b_check   (ex_b_check),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .flush        (flush),
        .br_count     (br_count),
        .mis_count    (mis_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic put_branch(input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        if_valid     = 1'b1;
        if_is_branch = 1'b1;
        if_pc        = pc;
        if_imm       = imm;
        if_predict   = pred;
    endtask

    task automatic put_idle();
        if_valid     = 1'b0;
        if_is_branch = 1'b0;
        if_pc        = 32'hDEAD_0000;
        if_imm       = 32'd0;
        if_predict   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; ex_b_take = 1'b0;
        put_idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({redirect, flush, ex_b_check} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl got %b want 000", {redirect, flush, ex_b_check});
        end
        checks++;
        if (redirect_pc !== 32'd0 || br_count !== 16'd0 || mis_count !== 16'd0) begin
            errors++; $display("FAIL reset_regs got pc=%h br=%0d mis=%0d want 0/0/0", redirect_pc, br_count, mis_count);
        end
    endtask

    task automatic test_correct_taken();
        put_branch(32'h100, 32'h20, 1'b1);
        step();
        put_idle();
        step();
        checks++;
        if (ex_b_check !== 1'b1) begin
            errors++; $display("FAIL t1_check_in_ex got %b want 1", ex_b_check);
        end
        ex_b_take = 1'b1;
        step();
        ex_b_take = 1'b0;
        checks++;
        if ({ex_b_check, redirect, flush} !== 3'b000) begin
            errors++; $display("FAIL t1_no_redirect got %b want 000", {ex_b_check, redirect, flush});
        end
        checks++;
        if (br_count !== 16'd1 || mis_count !== 16'd0) begin
            errors++; $display("FAIL t1_counts got br=%0d mis=%0d want 1/0", br_count, mis_count);
        end
    endtask

    task automatic test_mispredict_taken();
        put_branch(32'h100, 32'h20, 1'b1);
        step();
        put_idle();
        step();
        ex_b_take = 1'b0;
        step();
        checks++;
        if ({redirect, flush, ex_b_check} !== 3'b110 || redirect_pc !== 32'h104) begin
            errors++; $display("FAIL t2_redirect got r/f/c=%b pc=%h want 110 pc=00000104", {redirect, flush, ex_b_check}, redirect_pc);
        end
        checks++;
        if (br_count !== 16'd2 || mis_count !== 16'd1) begin
            errors++; $display("FAIL t2_counts got br=%0d mis=%0d want 2/1", br_count, mis_count);
        end
        step();
        checks++;
        if ({redirect, flush, ex_b_check} !== 3'b000) begin
            errors++; $display("FAIL t2_one_cycle got %b want 000", {redirect, flush, ex_b_check});
        end
    endtask

    task automatic test_mispredict_not_taken();
        put_branch(32'h200, 32'hFFFF_FFF0, 1'b0);
        step();
        put_idle();
        step();
        ex_b_take = 1'b1;
        step();
        ex_b_take = 1'b0;
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h1F0) begin
            errors++; $display("FAIL t3_redirect_pc got r=%b pc=%h want 1 pc=000001f0", redirect, redirect_pc);
        end
        checks++;
        if (br_count !== 16'd3 || mis_count !== 16'd2) begin
            errors++; $display("FAIL t3_counts got br=%0d mis=%0d want 3/2", br_count, mis_count);
        end
        step();
    endtask

    task automatic test_stall_bubble();
        put_branch(32'h280, 32'h40, 1'b1);
        step();
        put_idle();
        stall = 1'b1;
        step();
        checks++;
        if (ex_b_check !== 1'b0) begin
            errors++; $display("FAIL stall_bubble got %b want 0", ex_b_check);
        end
        stall = 1'b0;
        step();
        checks++;
        if (ex_b_check !== 1'b1) begin
            errors++; $display("FAIL stall_release got %b want 1", ex_b_check);
        end
        ex_b_take = 1'b1;
        step();
        ex_b_take = 1'b0;
        checks++;
        if (br_count !== 16'd4 || mis_count !== 16'd2 || redirect !== 1'b0) begin
            errors++; $display("FAIL stall_counts got br=%0d mis=%0d r=%b want 4/2/0", br_count, mis_count, redirect);
        end
    endtask

    task automatic test_stall_mispredict();
        put_branch(32'h300, 32'h8, 1'b1);
        step();
        put_branch(32'h400, 32'h10, 1'b1);
        step();
        put_idle();
        stall = 1'b1;
        ex_b_take = 1'b0;
        step();
        checks++;
        if ({redirect, flush} !== 2'b11 || redirect_pc !== 32'h304) begin
            errors++; $display("FAIL t4_redirect got r/f=%b pc=%h want 11 pc=00000304", {redirect, flush}, redirect_pc);
        end
        stall = 1'b0;
        ex_b_take = 1'b1;
        step();
        ex_b_take = 1'b0;
        step();
        checks++;
        if ({ex_b_check, redirect, flush} !== 3'b000) begin
            errors++; $display("FAIL t4_squashed got %b want 000", {ex_b_check, redirect, flush});
        end
        step();
        checks++;
        if (br_count !== 16'd5 || mis_count !== 16'd3) begin
            errors++; $display("FAIL t4_counts got br=%0d mis=%0d want 5/3", br_count, mis_count);
        end
    endtask

    task automatic test_wrap();
        put_branch(32'hFFFF_FFFC, 32'h100, 1'b1);
        step();
        put_idle();
        step();
        ex_b_take = 1'b0;
        step();
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h0000_0000) begin
            errors++; $display("FAIL t7_wrap got r=%b pc=%h want 1 pc=00000000", redirect, redirect_pc);
        end
        step();
    endtask

    task automatic test_reset_in_redir();
        put_branch(32'h500, 32'h30, 1'b0);
        step();
        put_idle();
        step();
        ex_b_take = 1'b1;
        step();
        ex_b_take = 1'b0;
        checks++;
        if (redirect !== 1'b1 || br_count !== 16'd7 || mis_count !== 16'd5) begin
            errors++; $display("FAIL t6_pre got r=%b br=%0d mis=%0d want 1/7/5", redirect, br_count, mis_count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({redirect, flush, ex_b_check} !== 3'b000) begin
            errors++; $display("FAIL t6_async_ctrl got %b want 000", {redirect, flush, ex_b_check});
        end
        checks++;
        if (br_count !== 16'd0 || mis_count !== 16'd0 || redirect_pc !== 32'd0) begin
            errors++; $display("FAIL t6_async_regs got br=%0d mis=%0d pc=%h want 0/0/0", br_count, mis_count, redirect_pc);
        end
        @(negedge clk);
        rst = 1'b0;
        put_branch(32'h600, 32'h8, 1'b1);
        step();
        put_idle();
        step();
        checks++;
        if (ex_b_check !== 1'b1) begin
            errors++; $display("FAIL t6_run_after got %b want 1", ex_b_check);
        end
        ex_b_take = 1'b1;
        step();
        ex_b_take = 1'b0;
    endtask

    task automatic test_saturation();
        // Counters start at br=1 (one resolve after reset); 65536 more saturate br_count.
        put_branch(32'h700, 32'h10, 1'b1);
        ex_b_take = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            step();
        end
        put_idle();
        step();
        step();
        checks++;
        if (br_count !== 16'hFFFF) begin
            errors++; $display("FAIL t5_br_sat got %h want ffff", br_count);
        end
        checks++;
        if (mis_count !== 16'd0 || redirect !== 1'b0) begin
            errors++; $display("FAIL t5_no_mis got mis=%0d r=%b want 0/0", mis_count, redirect);
        end
        put_branch(32'h700, 32'h10, 1'b1);
        step();
        step();
        put_idle();
        step();
        step();
        ex_b_take = 1'b0;
        checks++;
        if (br_count !== 16'hFFFF) begin
            errors++; $display("FAIL t5_br_hold got %h want ffff", br_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_correct_taken();
        test_mispredict_taken();
        test_mispredict_not_taken();
        test_stall_bubble();
        test_stall_mispredict();
        test_wrap();
        test_reset_in_redir();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
